// File: rtl/pipe_arb_pkg.sv
// Shared definitions for the pipelined round-robin arbiter: FSM states and
// default parameter values.
package pipe_arb_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned WIDTH_DEF   = 8;
  localparam int unsigned LATENCY_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_arbiter_rr_arbiter.sv
// Round-robin grant: lowest requesting index at or above the priority pointer,
// wrapping around; produces a one-hot-or-zero grant vector.
module rr_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF
) (
  input  logic [NUM_REQ-1:0]                                req_i,
  input  logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]                                grant_o
);

  localparam int unsigned IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned IXW = IW + 1;

  logic [IXW-1:0] idx_s;
  logic           found_s;

  // Scan from the pointer upward (modulo NUM_REQ); first requester wins.
  always_comb begin
    grant_o = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s = {1'b0, ptr_i} + IXW'(k);
      if (idx_s >= IXW'(NUM_REQ)) begin
        idx_s = idx_s - IXW'(NUM_REQ);
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && req_i[idx_s[IW-1:0]]) begin
        grant_o[idx_s[IW-1:0]] = 1'b1;
        found_s                = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/pipe_arbiter.sv
// Shares one fixed-latency datapath among NUM_REQ requesters: round-robin issue,
// tag pipeline routing results back to their owner, and a flush/drain FSM.
module pipe_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned LATENCY = LATENCY_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0]   req_operand_1_i,
  input  logic [NUM_REQ*WIDTH-1:0]   req_operand_2_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic                       dp_valid_o,
  output logic [WIDTH-1:0]           dp_operand_1_o,
  output logic [WIDTH-1:0]           dp_operand_2_o,
  input  logic [WIDTH-1:0]           dp_result_i,
  output logic [NUM_REQ-1:0]         resp_valid_o,
  output logic [WIDTH-1:0]           resp_result_o,
  input  logic                       flush_i,
  output logic                       flush_done_o,
  output logic                       busy_o
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(LATENCY + 2);

  typedef struct packed {
    logic          vld;
    logic [IW-1:0] idx;
  } tag_t;

  state_e               state_q;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  tag_t [LATENCY:0]     tag_q;
  logic                 dp_valid_q;
  logic [WIDTH-1:0]     op1_q, op2_q;
  logic                 flush_done_q;

  logic [NUM_REQ-1:0]   grant_s, ready_s;
  logic                 xfer_s, resp_s;
  logic [IW-1:0]        gidx_s;
  logic [WIDTH-1:0]     op1_s, op2_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (grant_s)
  );

  // Grant gating, granted-index encode, operand select and next pointer/count.
  always_comb begin
    ready_s = (rst_i || (state_q == ST_DRAIN)) ? '0 : grant_s;
    xfer_s  = |ready_s;
    resp_s  = tag_q[LATENCY].vld;
    gidx_s  = '0;
    op1_s   = '0;
    op2_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ready_s[i]) begin
        gidx_s = IW'(i);
        op1_s  = req_operand_1_i[i*WIDTH +: WIDTH];
        op2_s  = req_operand_2_i[i*WIDTH +: WIDTH];
      end else begin
        gidx_s = gidx_s;
      end
    end
    if (xfer_s) begin
      ptr_d = (gidx_s == IW'(NUM_REQ - 1)) ? '0 : gidx_s + IW'(1);
    end else begin
      ptr_d = ptr_q;
    end
    case ({xfer_s, resp_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Issue registers, tag pipeline, counters and the IDLE/RUN/DRAIN FSM.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      tag_q        <= '0;
      dp_valid_q   <= 1'b0;
      op1_q        <= '0;
      op2_q        <= '0;
      flush_done_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      dp_valid_q <= xfer_s;
      if (xfer_s) begin
        op1_q <= op1_s;
        op2_q <= op2_s;
      end else begin
        op1_q <= op1_q;
        op2_q <= op2_q;
      end
      tag_q[0] <= '{vld: xfer_s, idx: gidx_s};
      for (int k = 1; k <= LATENCY; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
      flush_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (flush_i)     state_q <= ST_DRAIN;
          else if (xfer_s) state_q <= ST_RUN;
          else             state_q <= ST_IDLE;
        end
        ST_RUN: begin
          if (flush_i)                        state_q <= ST_DRAIN;
          else if ((cnt_q == '0) && !xfer_s)  state_q <= ST_IDLE;
          else                                state_q <= ST_RUN;
        end
        ST_DRAIN: begin
          // No issue happens here, so a zero count means everything has returned.
          if (cnt_q == '0) begin
            flush_done_q <= 1'b1;
            state_q      <= ST_IDLE;
          end else begin
            state_q <= ST_DRAIN;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Result routing to the requester recorded in the oldest tag stage.
  always_comb begin
    resp_valid_o = '0;
    if (resp_s) begin
      resp_valid_o[tag_q[LATENCY].idx] = 1'b1;
      resp_result_o                    = dp_result_i;
    end else begin
      resp_result_o = '0;
    end
  end

  assign req_ready_o    = ready_s;
  assign dp_valid_o     = dp_valid_q;
  assign dp_operand_1_o = op1_q;
  assign dp_operand_2_o = op2_q;
  assign flush_done_o   = flush_done_q;
  assign busy_o         = (state_q != ST_IDLE);

endmodule
